// File: rtl/stump_mem_responder.sv
// Stump bus memory responder: word RAM plus a memory-mapped peripheral page
// (LEDs, synchronised switches, compare timer, sticky W1C status flags).
module stump_mem_responder #(
  parameter int          RAM_AW  = 8,
  parameter logic [15:0] IO_BASE = 16'hFF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] address,
  input  logic [15:0] data_out,
  input  logic        mem_ren,
  input  logic        mem_wen,
  output logic [15:0] data_in,
  input  logic [7:0]  switches,
  output logic [7:0]  leds,
  output logic        timer_flag,
  output logic        bus_err
);
  localparam int RAM_WORDS = 1 << RAM_AW;

  logic [15:0] ram [RAM_WORDS];
  logic [15:0] cnt, cnt_nxt, cmp, rd_word;
  logic        en, auto_rl;
  logic [1:0]  status, st_set, st_clr;
  logic [7:0]  sw_meta, sw_sync, offset;
  logic        ram_hit, io_hit, mapped, match;
  logic        wr_led, wr_cmp, wr_ctrl, wr_stat;

  // RAM decode takes precedence so a large RAM_AW cannot alias the IO page
  assign ram_hit = 32'(address) < RAM_WORDS;
  assign io_hit  = !ram_hit && (address[15:8] == IO_BASE[15:8]);
  assign mapped  = ram_hit || io_hit;
  assign offset  = address[7:0];

  assign wr_led  = mem_wen && io_hit && (offset == 8'h00);
  assign wr_cmp  = mem_wen && io_hit && (offset == 8'h03);
  assign wr_ctrl = mem_wen && io_hit && (offset == 8'h04);
  assign wr_stat = mem_wen && io_hit && (offset == 8'h05);

  assign match  = en && (cnt == cmp);
  assign st_set = {((mem_ren || mem_wen) && !mapped) || (mem_ren && mem_wen), match};
  assign st_clr = wr_stat ? data_out[1:0] : 2'b00;

  always_comb begin
    cnt_nxt = cnt;
    if (wr_cmp)
      cnt_nxt = 16'h0000;
    else if (wr_ctrl && !data_out[0])
      cnt_nxt = cnt;  // disabling freezes the count on the writing edge
    else if (en)
      cnt_nxt = (auto_rl && match) ? 16'h0000 : cnt + 16'h0001;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      leds    <= 8'h00;
      cnt     <= 16'h0000;
      cmp     <= 16'h0000;
      en      <= 1'b0;
      auto_rl <= 1'b0;
      status  <= 2'b00;
      sw_meta <= 8'h00;
      sw_sync <= 8'h00;
    end else begin
      if (wr_led)  leds <= data_out[7:0];
      if (wr_cmp)  cmp  <= data_out;
      if (wr_ctrl) {auto_rl, en} <= data_out[1:0];
      cnt     <= cnt_nxt;
      status  <= (status & ~st_clr) | st_set;  // hardware set beats W1C
      sw_meta <= switches;
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_wen && ram_hit)
      ram[address[RAM_AW-1:0]] <= data_out;
  end

  always_comb begin
    rd_word = 16'h0000;
    if (ram_hit)
      rd_word = ram[address[RAM_AW-1:0]];
    else if (io_hit) begin
      case (offset)
        8'h00:   rd_word = {8'h00, leds};
        8'h01:   rd_word = {8'h00, sw_sync};
        8'h02:   rd_word = cnt;
        8'h03:   rd_word = cmp;
        8'h04:   rd_word = {14'h0000, auto_rl, en};
        8'h05:   rd_word = {14'h0000, status};
        default: rd_word = 16'h0000;
      endcase
    end
  end

  assign data_in    = (mem_ren && !mem_wen) ? rd_word : 16'h0000;
  assign timer_flag = status[0];
  assign bus_err    = status[1];
endmodule

// File: tb/tb_stump_mem_responder.sv
// Bench for stump_mem_responder: directed vector table, hand-written timer/
// switch/reset sequences, then random traffic against a behavioural model.
module tb_stump_mem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] address = 16'h0, data_out = 16'h0, data_in;
  logic        mem_ren = 1'b0, mem_wen = 1'b0;
  logic [7:0]  switches = 8'h00, leds;
  logic        timer_flag, bus_err;

  stump_mem_responder #(.RAM_AW(8), .IO_BASE(16'hFF00)) dut (
    .clk(clk), .rst(rst), .address(address), .data_out(data_out),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .data_in(data_in),
    .switches(switches), .leds(leds), .timer_flag(timer_flag), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One bus cycle: drive at negedge, optionally check read data, take the edge.
  task automatic op(input bit r, input bit re, input bit we, input logic [15:0] a,
                    input logic [15:0] d, input bit chk_rd, input logic [15:0] exp_rd);
    @(negedge clk);
    rst = r; mem_ren = re; mem_wen = we; address = a; data_out = d;
    #1;
    if (chk_rd) chk($sformatf("data_in @%h", a), data_in, exp_rd);
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    op(0, 0, 1, a, d, 0, 16'h0);
  endtask
  task automatic rd(input logic [15:0] a, input logic [15:0] e);
    op(0, 1, 0, a, 16'h0, 1, e);
  endtask
  task automatic idle();
    op(0, 0, 0, 16'h0, 16'h0, 1, 16'h0);
  endtask

  typedef struct {
    bit ren, wen;
    logic [15:0] addr, wd, exp_rd;
    logic [7:0]  exp_leds;
    bit exp_tf, exp_be;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t mk(bit re, bit we, logic [15:0] a, logic [15:0] d,
                              logic [15:0] e, logic [7:0] l, bit tf, bit be);
    vec_t v;
    v.ren = re; v.wen = we; v.addr = a; v.wd = d; v.exp_rd = e;
    v.exp_leds = l; v.exp_tf = tf; v.exp_be = be;
    return v;
  endfunction

  // ---------------- behavioural reference model ----------------
  logic [15:0] m_mem [int];
  logic [15:0] m_cnt, m_cmp;
  logic [7:0]  m_leds;
  logic [7:0]  sw_h [2];
  bit          m_en, m_auto;
  bit [1:0]    m_st;

  function automatic logic [15:0] m_read(bit re, bit we, logic [15:0] a);
    if (!re || we) return 16'h0;
    if (a < 16'h0100) return m_mem.exists(int'(a)) ? m_mem[int'(a)] : 16'h0;
    if (a[15:8] != 8'hFF) return 16'h0;
    case (a[7:0])
      8'h00: return {8'h0, m_leds};
      8'h01: return {8'h0, sw_h[1]};
      8'h02: return m_cnt;
      8'h03: return m_cmp;
      8'h04: return {14'h0, m_auto, m_en};
      8'h05: return {14'h0, m_st};
      default: return 16'h0;
    endcase
  endfunction

  task automatic m_step(bit r, bit re, bit we, logic [15:0] a, logic [15:0] d, logic [7:0] sw);
    bit mapped, err, hit;
    logic [15:0] c;
    if (r) begin
      m_cnt = 0; m_cmp = 0; m_leds = 0; m_en = 0; m_auto = 0; m_st = 0;
      sw_h[0] = 0; sw_h[1] = 0;
      return;
    end
    mapped = (a < 16'h0100) || (a[15:8] == 8'hFF);
    err = ((re || we) && !mapped) || (re && we);
    hit = m_en && (m_cnt == m_cmp);
    c = m_cnt;
    if (m_en) c = (m_auto && hit) ? 16'h0 : m_cnt + 16'h1;
    if (we && a == 16'hFF04 && !d[0]) c = m_cnt;
    if (we && a == 16'hFF03) c = 16'h0;
    m_cnt = c;
    if (we && a == 16'hFF05) m_st = m_st & ~d[1:0];
    if (hit) m_st[0] = 1'b1;
    if (err) m_st[1] = 1'b1;
    if (we) begin
      if (a < 16'h0100) m_mem[int'(a)] = d;
      if (a == 16'hFF00) m_leds = d[7:0];
      if (a == 16'hFF03) m_cmp = d;
      if (a == 16'hFF04) begin m_en = d[0]; m_auto = d[1]; end
    end
    sw_h[1] = sw_h[0];
    sw_h[0] = sw;
  endtask

  task automatic mop(bit r, bit re, bit we, logic [15:0] a, logic [15:0] d);
    logic [15:0] e;
    e = m_read(re, we, a);
    op(r, re, we, a, d, !r, e);
    m_step(r, re, we, a, d, switches);
    chk("leds", 16'(leds), 16'(m_leds));
    chk("timer_flag", 16'(timer_flag), 16'(m_st[0]));
    chk("bus_err", 16'(bus_err), 16'(m_st[1]));
  endtask

  initial begin
    // reset
    op(1, 0, 0, 16'h0, 16'h0, 0, 16'h0);
    op(1, 0, 0, 16'h0, 16'h0, 0, 16'h0);
    chk("rst data_in", data_in, 16'h0);
    chk("rst leds", 16'(leds), 16'h0);
    chk("rst timer_flag", 16'(timer_flag), 16'h0);
    chk("rst bus_err", 16'(bus_err), 16'h0);

    // directed vector table
    vt.push_back(mk(1, 0, 16'hFF02, 16'h0,    16'h0000, 8'h00, 0, 0));
    vt.push_back(mk(1, 0, 16'hFF04, 16'h0,    16'h0000, 8'h00, 0, 0));
    vt.push_back(mk(0, 1, 16'h0010, 16'h1234, 16'h0000, 8'h00, 0, 0));
    vt.push_back(mk(1, 0, 16'h0010, 16'h0,    16'h1234, 8'h00, 0, 0));
    vt.push_back(mk(0, 0, 16'h0010, 16'h0,    16'h0000, 8'h00, 0, 0));
    vt.push_back(mk(0, 1, 16'hFF00, 16'h00A5, 16'h0000, 8'hA5, 0, 0));
    vt.push_back(mk(1, 0, 16'hFF00, 16'h0,    16'h00A5, 8'hA5, 0, 0));
    vt.push_back(mk(1, 0, 16'h8000, 16'h0,    16'h0000, 8'hA5, 0, 1));
    vt.push_back(mk(1, 0, 16'hFF05, 16'h0,    16'h0002, 8'hA5, 0, 1));
    vt.push_back(mk(0, 1, 16'hFF05, 16'h0002, 16'h0000, 8'hA5, 0, 0));
    vt.push_back(mk(1, 1, 16'h0020, 16'hBEEF, 16'h0000, 8'hA5, 0, 1));
    vt.push_back(mk(1, 0, 16'h0020, 16'h0,    16'hBEEF, 8'hA5, 0, 1));
    vt.push_back(mk(0, 1, 16'hFF05, 16'h0003, 16'h0000, 8'hA5, 0, 0));
    vt.push_back(mk(1, 0, 16'h0100, 16'h0,    16'h0000, 8'hA5, 0, 1));
    vt.push_back(mk(0, 1, 16'hFF05, 16'h0002, 16'h0000, 8'hA5, 0, 0));
    vt.push_back(mk(1, 0, 16'hFF07, 16'h0,    16'h0000, 8'hA5, 0, 0));
    vt.push_back(mk(0, 1, 16'hFF07, 16'hFFFF, 16'h0000, 8'hA5, 0, 0));
    vt.push_back(mk(0, 1, 16'h9000, 16'h1111, 16'h0000, 8'hA5, 0, 1));
    vt.push_back(mk(0, 1, 16'hFF05, 16'h0001, 16'h0000, 8'hA5, 0, 1));
    vt.push_back(mk(1, 0, 16'hFF05, 16'h0,    16'h0002, 8'hA5, 0, 1));
    vt.push_back(mk(0, 1, 16'hFF05, 16'h0002, 16'h0000, 8'hA5, 0, 0));
    foreach (vt[i]) begin
      op(0, vt[i].ren, vt[i].wen, vt[i].addr, vt[i].wd, 1, vt[i].exp_rd);
      chk($sformatf("vec%0d leds", i), 16'(leds), 16'(vt[i].exp_leds));
      chk($sformatf("vec%0d timer_flag", i), 16'(timer_flag), 16'(vt[i].exp_tf));
      chk($sformatf("vec%0d bus_err", i), 16'(bus_err), 16'(vt[i].exp_be));
    end

    // switch synchroniser latency
    switches = 8'h3C;
    rd(16'hFF01, 16'h0000);
    rd(16'hFF01, 16'h0000);
    rd(16'hFF01, 16'h003C);
    rd(16'hFF01, 16'h003C);

    // timer with AUTO reload: flag on the 6th edge after enable, count back to 0
    wr(16'hFF03, 16'd5);
    wr(16'hFF04, 16'h0003);
    for (int k = 1; k <= 6; k++) begin
      idle();
      chk($sformatf("auto tf edge%0d", k), 16'(timer_flag), (k == 6) ? 16'h1 : 16'h0);
    end
    rd(16'hFF02, 16'h0000);
    wr(16'hFF05, 16'h0001);
    chk("w1c tf", 16'(timer_flag), 16'h0);
    wr(16'hFF04, 16'h0001);              // count now 3, no AUTO
    idle(); idle();
    chk("noauto tf pre", 16'(timer_flag), 16'h0);
    idle();
    chk("noauto tf", 16'(timer_flag), 16'h1);
    rd(16'hFF02, 16'd6);
    rd(16'hFF02, 16'd7);

    // W1C in the same cycle as a match: set wins
    wr(16'hFF03, 16'd3);
    idle(); idle(); idle();
    wr(16'hFF05, 16'h0001);
    chk("set beats w1c", 16'(timer_flag), 16'h1);
    wr(16'hFF05, 16'h0001);
    chk("w1c after", 16'(timer_flag), 16'h0);

    // CTRL write with EN=0 freezes the count (count is 5 here)
    wr(16'hFF04, 16'h0000);
    rd(16'hFF02, 16'd5);
    rd(16'hFF02, 16'd5);

    // CMP write coinciding with a match: count cleared, flag still set
    wr(16'hFF03, 16'd7);
    wr(16'hFF04, 16'h0001);
    repeat (7) idle();
    wr(16'hFF03, 16'h0100);
    chk("cmp+match tf", 16'(timer_flag), 16'h1);
    rd(16'hFF02, 16'h0000);

    // reset mid-transaction with timer running and leds=FF
    wr(16'hFF00, 16'h00FF);
    wr(16'h0030, 16'h1111);
    rd(16'h8000, 16'h0000);
    chk("pre-rst leds", 16'(leds), 16'h00FF);
    op(1, 0, 1, 16'h0030, 16'h5555, 0, 16'h0);
    chk("rst2 leds", 16'(leds), 16'h0);
    chk("rst2 timer_flag", 16'(timer_flag), 16'h0);
    chk("rst2 bus_err", 16'(bus_err), 16'h0);
    chk("rst2 data_in", data_in, 16'h0);
    rd(16'hFF02, 16'h0000);
    rd(16'hFF02, 16'h0000);
    rd(16'hFF03, 16'h0000);
    rd(16'hFF04, 16'h0000);
    rd(16'h0030, 16'h1111);
    rd(16'h0010, 16'h1234);

    // random traffic against the model
    mop(1, 0, 0, 16'h0, 16'h0);
    for (int i = 0; i < 16; i++) mop(0, 0, 1, 16'h0040 + 16'(i), 16'($urandom));
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] a, d;
      bit re, we;
      int kind, rw;
      kind = $urandom_range(0, 9);
      if (kind <= 2)      a = 16'h0040 + 16'($urandom_range(0, 15));
      else if (kind <= 7) a = 16'hFF00 + 16'($urandom_range(0, 7));
      else                a = 16'($urandom_range(16'h0100, 16'hFEFF));
      rw = $urandom_range(0, 15);
      re = (rw <= 7) || (rw == 15);
      we = (rw >= 8 && rw <= 11) || (rw == 15);
      d = 16'($urandom);
      if (a == 16'hFF03) d = 16'($urandom_range(0, 24));
      if (a == 16'hFF05 || a == 16'hFF04) d = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) switches = 8'($urandom);
      mop(($urandom_range(0, 199) == 0), re, we, a, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
